da_tap_feeder: RTL
==================

# da_tap_feeder

Upstream feeder for the 8-tap distributed-arithmetic FIR core (`distr_arith`). It accepts one signed 8-bit input sample per frame over a valid/ready handshake and maintains the 8-deep tap delay line. It presents the taps to the core's `x1_bit`…`x8_bit` inputs and holds them stable for the full accumulation frame. It marks the start and end of each frame so the downstream core and result capture stay cycle-aligned.

## Interface
- `DATA_W`, 8: sample width, two's complement; tap outputs use the same width.
- `FRAME_CYCLES`, 16: clocks per frame, matching the DA core accumulation length. Legal range is 2..256.
- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_data`  in  DATA_W  signed input sample.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  feeder can accept a sample this cycle.
- `x1_bit` … `x8_bit`  out  DATA_W each  tap outputs to the DA core. `x1_bit` is the newest sample and `x8_bit` the oldest.
- `frame_start`  out  1  one-cycle pulse in the first cycle the new taps are visible.
- `frame_done`  out  1  high in the last cycle of a frame; the core's `sum` is sampled here.
- `frame_busy`  out  1  a frame is in progress.
- `frame_cnt`  out  16  number of completed frames, modulo 2^16.
- `flush`  in  1  synchronous delay-line clear. The port exists only with `DA_FEEDER_FLUSH_EN`.

## Operation
- Reset values (when `reset`=0):
  - state IDLE, cycle counter `cnt`=0.
  - all taps 0.
  - `frame_start`=0, `frame_done`=0, `frame_busy`=0, `frame_cnt`=0.
  - `in_ready`=1 once reset is released.
- FSM states:
  - IDLE: `in_ready`=1, `frame_busy`=0.
  - RUN: `frame_busy`=1. `cnt` counts from 0 to FRAME_CYCLES-1.
- Accept condition: `in_valid && in_ready` at a rising edge. On accept:
  - `x1`←`in_data`, and `xk`←`x(k-1)` for k=2..8; `x8` is discarded.
  - state←RUN, `cnt`←0, `frame_start`←1.
- In RUN:
  - `cnt` increments by 1 each cycle.
  - `frame_done` = (`cnt`==FRAME_CYCLES-1), decoded from registered state.
  - `in_ready` = `frame_done`.
- At the last cycle of a frame:
  - If a sample is accepted, the next frame starts back-to-back with `cnt`←0.
  - Otherwise state←IDLE.
  - In either case `frame_cnt` increments, wrapping 0xFFFF→0x0000.
- `in_ready` depends only on registered state, never on `in_valid`.
- Taps change only on accept, so they are stable for every cycle of a frame.
- Sample values pass through bit-exact, with no saturation or rescaling.
- `in_valid` low during RUN has no effect. `in_data` is ignored whenever `in_ready`=0.

## Timing
- Accept edge T: taps and `frame_start` are visible from T+ (cycle 0 of the frame).
- `frame_done` is high in cycle FRAME_CYCLES-1, i.e. 15 clocks after the `frame_start` cycle at the default.
- Maximum throughput is one sample per FRAME_CYCLES clocks.
- With continuous `in_valid`, `frame_start` pulses every 16 cycles with no gap.
- Reset asserted mid-frame: everything returns to reset values immediately (asynchronously). The partial frame produces no `frame_done` and no `frame_cnt` increment.

## Configuration
- `DA_FEEDER_FLUSH_EN` defined:
  - The `flush` port exists.
  - `flush`=1 at an edge zeroes all taps, sets state←IDLE and `cnt`←0, and clears `frame_start`.
  - `frame_cnt` is preserved.
  - `flush` overrides any accept in the same cycle, and `in_ready` is forced to 0 while `flush`=1.
- `DA_FEEDER_FLUSH_EN` undefined: no `flush` port. The delay line clears only via `reset`.

## Test plan
- Reset check: hold `reset`=0 and check all taps =0, `frame_busy`=0, `frame_cnt`=0. Release reset and check `in_ready`=1.
- Back-to-back ramp: drive `in_data`=1,2,3 with `in_valid` held high.
  - `frame_start` pulses exactly 16 cycles apart.
  - In frame 3: `x1`=3, `x2`=2, `x3`=1, `x4`..`x8`=0.
  - `frame_cnt`=3 after the third `frame_done`.
- Full line and extremes: feed -128, 127, -1, 0, 5, -5, 64, -64, then 9.
  - In the last frame: `x1`=9, `x2`=-64, …, `x8`=127. The value -128 has shifted out.
- Stall: drive `in_valid` high only at cycle 5 of a frame.
  - `in_ready`=0 for `cnt` 0..14, so the sample is not taken.
  - The sample is taken at `cnt`=15 only if `in_valid` is still high then.
  - Drop `in_valid` at `cnt`=15 and check the FSM returns to IDLE with `frame_busy`=0.
- Reset at `cnt`=7: check no `frame_done`, taps 0, and `frame_cnt` unchanged from its pre-frame value reset to 0.
- Flush (macro on): pulse `flush` together with a valid sample at `cnt`=15.
  - Sample rejected, taps all 0, state IDLE.
  - `frame_cnt` unchanged.

Source files
------------

// File: rtl/da_tap_feeder.sv
// Tap delay-line feeder for the 8-tap DA FIR core: one sample per FRAME_CYCLES-clock frame, taps held for the whole frame.
// in_ready comes only from registered state; optional synchronous delay-line clear via `flush` when DA_FEEDER_FLUSH_EN is defined.
module da_tap_feeder #(
  parameter int DATA_W       = 8,
  parameter int FRAME_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic signed [DATA_W-1:0] x1_bit,
  output logic signed [DATA_W-1:0] x2_bit,
  output logic signed [DATA_W-1:0] x3_bit,
  output logic signed [DATA_W-1:0] x4_bit,
  output logic signed [DATA_W-1:0] x5_bit,
  output logic signed [DATA_W-1:0] x6_bit,
  output logic signed [DATA_W-1:0] x7_bit,
  output logic signed [DATA_W-1:0] x8_bit,
  output logic                     frame_start,
  output logic                     frame_done,
  output logic                     frame_busy,
  output logic [15:0]              frame_cnt
`ifdef DA_FEEDER_FLUSH_EN
  ,
  input  logic                     flush
`endif
);

  localparam int CW = (FRAME_CYCLES > 2) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                     state_q;
  logic [CW-1:0]              cnt_q;
  logic signed [DATA_W-1:0]   taps_q [8];
  logic                       frame_start_q;
  logic [15:0]                frame_cnt_q;
  logic                       flush_w;
  logic                       accept;

`ifdef DA_FEEDER_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign frame_done  = (state_q == RUN) && (cnt_q == LAST);
  assign frame_busy  = (state_q == RUN);
  assign in_ready    = ((state_q == IDLE) || frame_done) && !flush_w;
  assign accept      = in_valid && in_ready;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

  assign x1_bit = taps_q[0];
  assign x2_bit = taps_q[1];
  assign x3_bit = taps_q[2];
  assign x4_bit = taps_q[3];
  assign x5_bit = taps_q[4];
  assign x6_bit = taps_q[5];
  assign x7_bit = taps_q[6];
  assign x8_bit = taps_q[7];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      for (int k = 0; k < 8; k++) taps_q[k] <= '0;
    end else begin
      // A flushed frame is abandoned, so it is not counted as completed.
      if (frame_done && !flush_w) frame_cnt_q <= frame_cnt_q + 16'd1;

      if (flush_w) begin
        state_q       <= IDLE;
        cnt_q         <= '0;
        frame_start_q <= 1'b0;
        for (int k = 0; k < 8; k++) taps_q[k] <= '0;
      end else if (accept) begin
        taps_q[0] <= in_data;
        for (int k = 1; k < 8; k++) taps_q[k] <= taps_q[k-1];
        state_q       <= RUN;
        cnt_q         <= '0;
        frame_start_q <= 1'b1;
      end else begin
        frame_start_q <= 1'b0;
        if (state_q == RUN) begin
          if (frame_done) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      end
    end
  end

endmodule
